bus_arbiter: RTL

- Two-master, five-slave system bus controller. It sits between the core data port (M0) and a second master, such as a future DMA engine or debug port (M1), and the ROM/SRAM/UART/TIMER/GPIO slaves.
- It performs round-robin arbitration, decodes the address region into slave chip-enables, and muxes the slave GNT and RDATA back to the owning master.
- It terminates unmapped or hung accesses with an error response.
- It replaces the combinational CE decode and GNT/RDATA muxing at system level.

---
 rtl/bus_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin system bus arbiter: slave chip-enable decode,
// GNT/RDATA return muxing, decode-miss and timeout error termination.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 16
) (
    input  logic           i_CLK,
    input  logic           i_RST,
    input  logic           i_M0_REQ,
    input  logic           i_M0_RE,
    input  logic           i_M0_WE,
    input  logic [31:0]    i_M0_ADDR,
    input  logic [31:0]    i_M0_WDATA,
    input  logic [1:0]     i_M0_HB,
    output logic           o_M0_GNT,
    output logic [31:0]    o_M0_RDATA,
    output logic           o_M0_ERR,
    input  logic           i_M1_REQ,
    input  logic           i_M1_RE,
    input  logic           i_M1_WE,
    input  logic [31:0]    i_M1_ADDR,
    input  logic [31:0]    i_M1_WDATA,
    input  logic [1:0]     i_M1_HB,
    output logic           o_M1_GNT,
    output logic [31:0]    o_M1_RDATA,
    output logic           o_M1_ERR,
    output logic           o_S_REQ,
    output logic           o_S_RE,
    output logic           o_S_WE,
    output logic [31:0]    o_S_ADDR,
    output logic [31:0]    o_S_WDATA,
    output logic [1:0]     o_S_HB,
    output logic [4:0]     o_S_CE,
    input  logic [4:0]     i_S_GNT,
    input  logic [159:0]   i_S_RDATA
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic        m0_rq, m1_rq;
    logic        own_req, own_re, own_we, own_rq;
    logic [31:0] own_addr, own_wdata;
    logic [1:0]  own_hb;
    logic [4:0]  dec;
    logic [31:0] sel_rdata;
    logic        hit, to_hit;
    logic        done, err;
    logic [31:0] rdata;

    assign m0_rq = i_M0_REQ & (i_M0_RE | i_M0_WE);
    assign m1_rq = i_M1_REQ & (i_M1_RE | i_M1_WE);

    assign own_req   = owner_q ? i_M1_REQ   : i_M0_REQ;
    assign own_re    = owner_q ? i_M1_RE    : i_M0_RE;
    assign own_we    = owner_q ? i_M1_WE    : i_M0_WE;
    assign own_addr  = owner_q ? i_M1_ADDR  : i_M0_ADDR;
    assign own_wdata = owner_q ? i_M1_WDATA : i_M0_WDATA;
    assign own_hb    = owner_q ? i_M1_HB    : i_M0_HB;
    assign own_rq    = own_req & (own_re | own_we);

    always_comb begin
        case (own_addr[31:28])
            4'h8:    dec = 5'b00001;
            4'h9:    dec = 5'b00010;
            4'hA:    dec = 5'b00100;
            4'hB:    dec = 5'b01000;
            4'hC:    dec = 5'b10000;
            default: dec = 5'b00000;
        endcase
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < 5; k++) begin
            if (dec[k]) sel_rdata = i_S_RDATA[32*k +: 32];
        end
    end

    // only the selected slave's grant may complete the access
    assign hit    = |(dec & i_S_GNT);
    assign to_hit = (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        err       = 1'b0;
        rdata     = '0;
        o_S_REQ   = 1'b0;
        o_S_RE    = 1'b0;
        o_S_WE    = 1'b0;
        o_S_ADDR  = '0;
        o_S_WDATA = '0;
        o_S_HB    = '0;
        o_S_CE    = '0;
        unique case (state_q)
            IDLE: begin
                if (m0_rq && m1_rq) begin
                    owner_d = ~last_q;
                    state_d = ACTIVE;
                end else if (m0_rq || m1_rq) begin
                    owner_d = m1_rq;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!own_rq) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    o_S_REQ   = own_req;
                    o_S_RE    = own_re;
                    o_S_WE    = own_we;
                    o_S_ADDR  = {4'h0, own_addr[27:0]};
                    o_S_WDATA = own_wdata;
                    o_S_HB    = own_hb;
                    o_S_CE    = dec;
                    if (dec == 5'b0) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (hit) begin
                        done  = 1'b1;
                        rdata = sel_rdata;
                    end else if (to_hit) begin
                        done   = 1'b1;
                        err    = 1'b1;
                        o_S_CE = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (done) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    assign o_M0_GNT   = done & ~owner_q;
    assign o_M0_ERR   = err & ~owner_q;
    assign o_M0_RDATA = owner_q ? '0 : rdata;
    assign o_M1_GNT   = done & owner_q;
    assign o_M1_ERR   = err & owner_q;
    assign o_M1_RDATA = owner_q ? rdata : '0;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
